// File: rtl/blink_pkg.sv
// Shared mode encodings and small helpers for the blink_bank LED driver.
package blink_pkg;

    localparam int MODE_W = 2;

    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_OFF     = 2'b00;
    localparam mode_t MODE_ON      = 2'b01;
    localparam mode_t MODE_BLINK   = 2'b10;
    localparam mode_t MODE_ONESHOT = 2'b11;

    // Only the two timed modes advance their phase on a tick.
    function automatic logic is_running(input mode_t mode);
        return (mode == MODE_BLINK) || (mode == MODE_ONESHOT);
    endfunction

endpackage

// File: rtl/blink_if.sv
// Configuration write port: one channel's mode/period/duty per strobe.
interface blink_if
    import blink_pkg::*;
#(
    parameter int CH_W  = 2,
    parameter int CNT_W = 16
);
    logic             cfg_we;
    logic [CH_W-1:0]  cfg_chan;
    mode_t            cfg_mode;
    logic [CNT_W-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_duty;

    modport master (
        output cfg_we, cfg_chan, cfg_mode, cfg_period, cfg_duty
    );

    modport slave (
        input cfg_we, cfg_chan, cfg_mode, cfg_period, cfg_duty
    );

endinterface

// File: rtl/blink_channel.sv
// One blink channel: holds its own mode/period/duty/phase and decodes its LED.
module blink_channel
    import blink_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             we,
    input  mode_t            mode,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] duty,
    output logic             blink,
    output logic             done
);

    mode_t            mode_q,   mode_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] duty_q,   duty_d;
    logic [CNT_W-1:0] phase_q,  phase_d;
    logic             done_q,   done_d;
    logic [CNT_W-1:0] eff_period;

    assign eff_period = (period_q == '0) ? CNT_W'(1) : period_q;

    // NOTE: every output of this block is given a default first so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        mode_d   = mode_q;
        period_d = period_q;
        duty_d   = duty_q;
        phase_d  = phase_q;
        done_d   = 1'b0;
        if (we) begin
            // A write outranks a coincident tick, so an overwritten oneshot never reports done.
            mode_d   = mode;
            period_d = period;
            duty_d   = duty;
            phase_d  = '0;
        end else if (tick && is_running(mode_q)) begin
            if (phase_q >= eff_period - CNT_W'(1)) begin
                phase_d = '0;
                if (mode_q == MODE_ONESHOT) begin
                    mode_d = MODE_OFF;
                    done_d = 1'b1;
                end
            end else begin
                phase_d = phase_q + CNT_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample
    // their next values together at the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q   <= MODE_OFF;
            period_q <= '0;
            duty_q   <= '0;
            phase_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            period_q <= period_d;
            duty_q   <= duty_d;
            phase_q  <= phase_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        blink = 1'b0;
        case (mode_q)
            MODE_OFF:     blink = 1'b0;
            MODE_ON:      blink = 1'b1;
            MODE_BLINK,
            MODE_ONESHOT: blink = (phase_q < duty_q);
            default:      blink = 1'b0;
        endcase
    end

    assign done = done_q;

endmodule

// File: rtl/blink_bank.sv
// Multi-channel LED blinker: a shared prescaler tick drives CHANNELS
// independently configured blink/oneshot channels.
module blink_bank
    import blink_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16,
    parameter int PRESCALE = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    blink_if.slave              cfg,
    output logic                tick,
    output logic [CHANNELS-1:0] blink_out,
    output logic [CHANNELS-1:0] oneshot_done
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]     ps_q;
    logic [CHANNELS-1:0] sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_q <= '0;
        end else if (ena) begin
            ps_q <= (ps_q == PS_MAX) ? '0 : ps_q + PS_W'(1);
        end
    end

    assign tick = ena && (ps_q == PS_MAX);

    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : g_chan
            // Indices at or above CHANNELS match no channel and are dropped.
            assign sel[i] = cfg.cfg_we && (cfg.cfg_chan == CH_W'(i));

            blink_channel #(
                .CNT_W (CNT_W)
            ) u_chan (
                .clk    (clk),
                .rst    (rst),
                .tick   (tick),
                .we     (sel[i]),
                .mode   (cfg.cfg_mode),
                .period (cfg.cfg_period),
                .duty   (cfg.cfg_duty),
                .blink  (blink_out[i]),
                .done   (oneshot_done[i])
            );
        end
    endgenerate

endmodule
